// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March-style BIST initiator that owns both RAM ports for a test run
// and reports pass/fail, first failing address/data and a saturating error count.
module ram_bist_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 4,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic          write_en,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  output logic          read_en,
  output logic [AW-1:0] read_addr,
  input  logic [DW-1:0] read_data
);
  typedef enum logic [2:0] {IDLE, W0, R0W1, R1W0, R0, DRAIN, DONE} state_e;
  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] DRAIN_LAST = AW'(READ_LAT - 1);
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ph_q, ph_d;
  logic [DW-1:0] pat_q, pat_d;
  logic [7:0]    err_q, err_d;
  logic          busy_q, done_q, pass_q;
  logic [AW-1:0] fail_addr_q;
  logic [DW-1:0] fail_data_q;
  logic          we_q, re_q;
  logic [AW-1:0] wa_q, ra_q;
  logic [DW-1:0] wd_q, exp_q;
  logic          accept, mism, first, rd_d, wr_d, rw_d;
  // Outstanding reads: {valid, addr, expected} delayed until read_data is valid
  logic          pv_q [READ_LAT];
  logic [AW-1:0] pa_q [READ_LAT];
  logic [DW-1:0] pe_q [READ_LAT];
  always_comb begin
    accept  = start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    addr_d  = addr_q;
    ph_d    = 1'b0;
    pat_d   = accept ? pattern : pat_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = W0;
          addr_d  = '0;
        end
      end
      W0: begin
        addr_d  = addr_q + 1'b1;
        state_d = (addr_q == LAST) ? R0W1 : W0;
      end
      R0W1: begin
        ph_d = !ph_q;
        if (ph_q) begin
          addr_d  = (addr_q == LAST) ? LAST : addr_q + 1'b1;
          state_d = (addr_q == LAST) ? R1W0 : R0W1;
        end
      end
      R1W0: begin
        ph_d = !ph_q;
        if (ph_q) begin
          addr_d  = (addr_q == '0) ? '0 : addr_q - 1'b1;
          state_d = (addr_q == '0) ? R0 : R1W0;
        end
      end
      R0: begin
        addr_d  = addr_q + 1'b1;
        state_d = (addr_q == LAST) ? DRAIN : R0;
      end
      DRAIN: begin
        addr_d  = addr_q + 1'b1;
        state_d = (addr_q == DRAIN_LAST) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    rw_d  = state_d == R0W1 || state_d == R1W0;
    rd_d  = state_d == R0 || (rw_d && !ph_d);
    wr_d  = state_d == W0 || (rw_d && ph_d);
    mism  = pv_q[READ_LAT-1] && read_data != pe_q[READ_LAT-1];
    first = mism && err_q == 8'd0;
    err_d = accept ? 8'd0 : (mism && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      pat_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      re_q        <= 1'b0;
      ra_q        <= '0;
      exp_q       <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      pat_q       <= pat_d;
      err_q       <= err_d;
      busy_q      <= state_d inside {W0, R0W1, R1W0, R0, DRAIN};
      done_q      <= state_d == DONE;
      pass_q      <= accept ? 1'b0 : (state_d == DONE && state_q != DONE) ? err_d == 8'd0 : pass_q;
      fail_addr_q <= accept ? '0 : first ? pa_q[READ_LAT-1] : fail_addr_q;
      fail_data_q <= accept ? '0 : first ? read_data : fail_data_q;
      we_q        <= wr_d;
      wa_q        <= wr_d ? addr_d : '0;
      wd_q        <= !wr_d ? '0 : (state_d == R0W1) ? ~pat_d : pat_d;
      re_q        <= rd_d;
      ra_q        <= rd_d ? addr_d : '0;
      exp_q       <= (state_d == R1W0) ? ~pat_d : pat_d;
      pv_q[0]     <= re_q;
      pa_q[0]     <= ra_q;
      pe_q[0]     <= exp_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign write_en   = we_q;
  assign write_addr = wa_q;
  assign write_data = wd_q;
  assign read_en    = re_q;
  assign read_addr  = ra_q;
endmodule
